// File: rtl/alu_ctrl_pkg.sv
// Shared types and encodings for the ALU control sequencer.
// Holds ALU op codes, sequencer states and RV32I opcode/funct constants.
package alu_ctrl_pkg;

   typedef enum logic [2:0] {
      ALU_ADD = 3'b000,
      ALU_SUB = 3'b001,
      ALU_AND = 3'b010,
      ALU_OR  = 3'b011,
      ALU_SLT = 3'b100
   } alu_op_e;

   typedef enum logic [1:0] {
      S_IDLE,
      S_DECODE,
      S_EXEC,
      S_WB
   } seq_state_e;

   localparam logic [6:0] OP_R = 7'b0110011;
   localparam logic [6:0] OP_I = 7'b0010011;
   localparam logic [6:0] OP_B = 7'b1100011;

   localparam logic [2:0] F3_ADD = 3'b000;
   localparam logic [2:0] F3_SLT = 3'b010;
   localparam logic [2:0] F3_OR  = 3'b110;
   localparam logic [2:0] F3_AND = 3'b111;
   localparam logic [2:0] F3_BEQ = 3'b000;
   localparam logic [2:0] F3_BNE = 3'b001;

   localparam logic [6:0] F7_BASE = 7'b0000000;
   localparam logic [6:0] F7_ALT  = 7'b0100000;

   // funct3 values shared by R-type and I-type arithmetic
   function automatic logic f3_is_alu(logic [2:0] f3);
      return (f3 == F3_ADD) || (f3 == F3_SLT) ||
             (f3 == F3_OR)  || (f3 == F3_AND);
   endfunction

   function automatic alu_op_e f3_to_op(logic [2:0] f3);
      alu_op_e op;
      op = ALU_ADD;
      case (f3)
         F3_SLT:  op = ALU_SLT;
         F3_OR:   op = ALU_OR;
         F3_AND:  op = ALU_AND;
         default: op = ALU_ADD;
      endcase
      return op;
   endfunction

endpackage

// File: rtl/alu_ctrl_dec.sv
// Combinational RV32I decoder for the ALU control sequencer.
// Ports: i_instr in; o_alu_ctrl/o_alu_src/o_imm, register fields,
// o_is_branch/o_is_bne/o_writes_rd/o_legal out. Illegal words
// decode to zero controls and immediate.
module alu_ctrl_dec
   import alu_ctrl_pkg::*;
#(
   parameter int D_WIDTH = 32,
   parameter int A_WIDTH = 5
) (
   input  logic [31:0]        i_instr,
   output alu_op_e            o_alu_ctrl,
   output logic               o_alu_src,
   output logic [D_WIDTH-1:0] o_imm,
   output logic [A_WIDTH-1:0] o_rs1,
   output logic [A_WIDTH-1:0] o_rs2,
   output logic [A_WIDTH-1:0] o_rd,
   output logic               o_is_branch,
   output logic               o_is_bne,
   output logic               o_writes_rd,
   output logic               o_legal
);

   logic [6:0] w_opcode;
   logic [2:0] w_f3;
   logic [6:0] w_f7;
   logic       w_r_ok;
   logic       w_i_ok;
   logic       w_b_ok;

   assign w_opcode = i_instr[6:0];
   assign w_f3     = i_instr[14:12];
   assign w_f7     = i_instr[31:25];

   assign o_rs1 = A_WIDTH'(i_instr[19:15]);
   assign o_rs2 = A_WIDTH'(i_instr[24:20]);
   assign o_rd  = A_WIDTH'(i_instr[11:7]);

   // funct7 = 0100000 is only meaningful for sub
   assign w_r_ok = (w_opcode == OP_R) &&
                   (((w_f7 == F7_BASE) && f3_is_alu(w_f3)) ||
                    ((w_f7 == F7_ALT) && (w_f3 == F3_ADD)));
   assign w_i_ok = (w_opcode == OP_I) && f3_is_alu(w_f3);
   assign w_b_ok = (w_opcode == OP_B) &&
                   ((w_f3 == F3_BEQ) || (w_f3 == F3_BNE));

   always_comb begin
      o_alu_ctrl  = ALU_ADD;
      o_alu_src   = 1'b0;
      o_imm       = '0;
      o_is_branch = 1'b0;
      o_is_bne    = 1'b0;
      o_writes_rd = 1'b0;
      o_legal     = 1'b0;
      unique case (1'b1)
         w_r_ok: begin
            o_alu_ctrl  = (w_f7 == F7_ALT) ? ALU_SUB
                                           : f3_to_op(w_f3);
            o_writes_rd = 1'b1;
            o_legal     = 1'b1;
         end
         w_i_ok: begin
            o_alu_ctrl  = f3_to_op(w_f3);
            o_alu_src   = 1'b1;
            o_imm       = {{(D_WIDTH-12){i_instr[31]}},
                           i_instr[31:20]};
            o_writes_rd = 1'b1;
            o_legal     = 1'b1;
         end
         w_b_ok: begin
            o_alu_ctrl  = ALU_SUB;
            o_imm       = {{(D_WIDTH-13){i_instr[31]}},
                           i_instr[31], i_instr[7],
                           i_instr[30:25], i_instr[11:8],
                           1'b0};
            o_is_branch = 1'b1;
            o_is_bne    = (w_f3 == F3_BNE);
            o_legal     = 1'b1;
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/alu_ctrl_seq.sv
// Multi-cycle sequencer IDLE->DECODE->EXEC->WB driving ALU controls.
// Ports: clk, rst_n, instr_valid/instr/instr_ready, alu_eq in;
// alu_ctrl, alu_src, imm_out, rs1/rs2/rd_addr, reg_write, pc_src,
// illegal out. ALU_CTRL_SEQ_PERF_EN adds retired_cnt/illegal_cnt.
module alu_ctrl_seq
   import alu_ctrl_pkg::*;
#(
   parameter int D_WIDTH = 32,
   parameter int A_WIDTH = 5
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               instr_valid,
   input  logic [31:0]        instr,
   output logic               instr_ready,
   input  logic               alu_eq,
   output logic [2:0]         alu_ctrl,
   output logic               alu_src,
   output logic [D_WIDTH-1:0] imm_out,
   output logic [A_WIDTH-1:0] rs1_addr,
   output logic [A_WIDTH-1:0] rs2_addr,
   output logic [A_WIDTH-1:0] rd_addr,
   output logic               reg_write,
   output logic               pc_src,
   output logic               illegal
`ifdef ALU_CTRL_SEQ_PERF_EN
   ,
   output logic [31:0]        retired_cnt,
   output logic [15:0]        illegal_cnt
`endif
);

   seq_state_e r_state;
   seq_state_e w_next;
   logic [31:0] r_instr;
   logic        r_eq;
   logic        r_ready;
   logic        w_accept;

   alu_op_e            w_op;
   logic               w_src;
   logic [D_WIDTH-1:0] w_imm;
   logic [A_WIDTH-1:0] w_rs1;
   logic [A_WIDTH-1:0] w_rs2;
   logic [A_WIDTH-1:0] w_rd;
   logic               w_is_branch;
   logic               w_is_bne;
   logic               w_writes_rd;
   logic               w_legal;

   // Decoding the latched word keeps controls stable until the
   // next accept, and a reset clears them along with the word.
   alu_ctrl_dec #(
      .D_WIDTH (D_WIDTH),
      .A_WIDTH (A_WIDTH)
   ) u_dec (
      .i_instr     (r_instr),
      .o_alu_ctrl  (w_op),
      .o_alu_src   (w_src),
      .o_imm       (w_imm),
      .o_rs1       (w_rs1),
      .o_rs2       (w_rs2),
      .o_rd        (w_rd),
      .o_is_branch (w_is_branch),
      .o_is_bne    (w_is_bne),
      .o_writes_rd (w_writes_rd),
      .o_legal     (w_legal)
   );

   // r_ready is a flop so ready stays low through the reset
   // window and rises on the first edge after release.
   assign w_accept    = instr_valid & r_ready;
   assign instr_ready = r_ready;

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:   if (w_accept) w_next = S_DECODE;
         S_DECODE: w_next = w_legal ? S_EXEC : S_IDLE;
         S_EXEC:   w_next = S_WB;
         S_WB:     w_next = S_IDLE;
         default:  w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
         r_ready <= 1'b0;
         r_instr <= '0;
         r_eq    <= 1'b0;
      end else begin
         r_state <= w_next;
         r_ready <= (w_next == S_IDLE);
         if (w_accept)
            r_instr <= instr;
         if (r_state == S_EXEC)
            r_eq <= alu_eq;
      end
   end

   assign alu_ctrl = w_op;
   assign alu_src  = w_src;
   assign imm_out  = w_imm;
   assign rs1_addr = w_rs1;
   assign rs2_addr = w_rs2;
   assign rd_addr  = w_rd;

   always_comb begin
      reg_write = 1'b0;
      pc_src    = 1'b0;
      illegal   = 1'b0;
      case (r_state)
         S_DECODE: illegal = ~w_legal;
         S_WB: begin
            reg_write = w_writes_rd & (w_rd != '0);
            pc_src    = w_is_branch & (w_is_bne ^ r_eq);
         end
         default: ;
      endcase
   end

`ifdef ALU_CTRL_SEQ_PERF_EN
   logic [31:0] r_retired;
   logic [15:0] r_illegal;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_retired <= '0;
         r_illegal <= '0;
      end else begin
         if (r_state == S_WB)
            r_retired <= r_retired + 32'd1;
         if (illegal)
            r_illegal <= r_illegal + 16'd1;
      end
   end

   assign retired_cnt = r_retired;
   assign illegal_cnt = r_illegal;
`endif

endmodule

// File: tb/tb_alu_ctrl_seq.sv
// Scoreboard bench for alu_ctrl_seq: driver queues expected strobes,
// monitor pops and checks kind and cycle when a strobe appears.
module tb_alu_ctrl_seq;

   logic        clk;
   logic        rst_n;
   logic        instr_valid;
   logic [31:0] instr;
   logic        instr_ready;
   logic        alu_eq;
   logic [2:0]  alu_ctrl;
   logic        alu_src;
   logic [31:0] imm_out;
   logic [4:0]  rs1_addr;
   logic [4:0]  rs2_addr;
   logic [4:0]  rd_addr;
   logic        reg_write;
   logic        pc_src;
   logic        illegal;
`ifdef ALU_CTRL_SEQ_PERF_EN
   logic [31:0] retired_cnt;
   logic [15:0] illegal_cnt;
`endif

   alu_ctrl_seq #(.D_WIDTH(32), .A_WIDTH(5)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .instr_valid (instr_valid),
      .instr       (instr),
      .instr_ready (instr_ready),
      .alu_eq      (alu_eq),
      .alu_ctrl    (alu_ctrl),
      .alu_src     (alu_src),
      .imm_out     (imm_out),
      .rs1_addr    (rs1_addr),
      .rs2_addr    (rs2_addr),
      .rd_addr     (rd_addr),
      .reg_write   (reg_write),
      .pc_src      (pc_src),
      .illegal     (illegal)
`ifdef ALU_CTRL_SEQ_PERF_EN
      ,
      .retired_cnt (retired_cnt),
      .illegal_cnt (illegal_cnt)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;
   int cyc   = 0;

   always @(posedge clk) cyc++;

   // kind: 0 none, 1 reg_write, 2 pc_src, 3 illegal
   typedef struct {
      int kind;
      int cyc;
   } exp_t;
   exp_t sbq[$];

   typedef struct {
      logic [31:0] ins;
      logic        eq;
      logic [2:0]  ctrl;
      logic        src;
      logic [31:0] imm;
      logic [4:0]  rd;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      int          kind;
      int          busy;
      string       nm;
   } vec_t;
   vec_t vecs[14];

   task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   function automatic vec_t mk(logic [31:0] ins, logic eq,
      logic [2:0] ctrl, logic src, logic [31:0] imm,
      logic [4:0] rd, logic [4:0] rs1, logic [4:0] rs2,
      int kind, int busy, string nm);
      vec_t v;
      v.ins = ins; v.eq = eq; v.ctrl = ctrl; v.src = src;
      v.imm = imm; v.rd = rd; v.rs1 = rs1; v.rs2 = rs2;
      v.kind = kind; v.busy = busy; v.nm = nm;
      return v;
   endfunction

   // Monitor: any strobe must match the head of the scoreboard.
   always @(negedge clk) begin
      if (rst_n && (reg_write || pc_src || illegal)) begin
         int k;
         exp_t e;
         k = reg_write ? 1 : (pc_src ? 2 : 3);
         chk("one_strobe", 32'(reg_write + pc_src + illegal), 1);
         if (sbq.size() == 0) begin
            chk("unexpected_strobe", 32'(k), 0);
         end else begin
            e = sbq.pop_front();
            chk("strobe_kind", 32'(k), 32'(e.kind));
            chk("strobe_cycle", 32'(cyc), 32'(e.cyc));
         end
      end
   end

   task automatic wait_ready();
      int n = 0;
      while (!instr_ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk("ready_wait", 32'(instr_ready), 1);
   endtask

   task automatic issue(vec_t v, bit hold);
      exp_t e;
      int low;
      wait_ready();
      instr       = v.ins;
      alu_eq      = v.eq;
      instr_valid = 1'b1;
      if (v.kind != 0) begin
         e.kind = v.kind;
         e.cyc  = cyc + ((v.kind == 3) ? 1 : 3);
         sbq.push_back(e);
      end
      @(negedge clk);
      if (!hold) instr_valid = 1'b0;
      chk({v.nm, "_ctrl"}, 32'(alu_ctrl), 32'(v.ctrl));
      chk({v.nm, "_src"}, 32'(alu_src), 32'(v.src));
      chk({v.nm, "_imm"}, imm_out, v.imm);
      chk({v.nm, "_rd"}, 32'(rd_addr), 32'(v.rd));
      chk({v.nm, "_rs1"}, 32'(rs1_addr), 32'(v.rs1));
      chk({v.nm, "_rs2"}, 32'(rs2_addr), 32'(v.rs2));
      low = 0;
      while (!instr_ready && low < 10) begin
         low++;
         @(negedge clk);
      end
      instr_valid = 1'b0;
      chk({v.nm, "_busy"}, 32'(low), 32'(v.busy));
      chk({v.nm, "_hold"}, 32'(alu_ctrl), 32'(v.ctrl));
   endtask

   function automatic logic [31:0] all_outs();
      return {alu_ctrl, alu_src, rd_addr, rs1_addr, rs2_addr,
              reg_write, pc_src, illegal, instr_ready} |
             imm_out;
   endfunction

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      vecs[0]  = mk(32'h002081B3, 0, 3'd0, 0, 32'h0,
                    5'd3, 5'd1, 5'd2, 1, 3, "add");
      vecs[1]  = mk(32'h402081B3, 0, 3'd1, 0, 32'h0,
                    5'd3, 5'd1, 5'd2, 1, 3, "sub");
      vecs[2]  = mk(32'hFFF00293, 0, 3'd0, 1, 32'hFFFFFFFF,
                    5'd5, 5'd0, 5'd31, 1, 3, "addi_m1");
      vecs[3]  = mk(32'h00208463, 1, 3'd1, 0, 32'h8,
                    5'd8, 5'd1, 5'd2, 2, 3, "beq_t");
      vecs[4]  = mk(32'h00208463, 0, 3'd1, 0, 32'h8,
                    5'd8, 5'd1, 5'd2, 0, 3, "beq_nt");
      vecs[5]  = mk(32'h00000000, 0, 3'd0, 0, 32'h0,
                    5'd0, 5'd0, 5'd0, 3, 1, "zero_ill");
      vecs[6]  = mk(32'h00100013, 0, 3'd0, 1, 32'h1,
                    5'd0, 5'd0, 5'd1, 0, 3, "addi_x0");
      vecs[7]  = mk(32'h0020E233, 0, 3'd3, 0, 32'h0,
                    5'd4, 5'd1, 5'd2, 1, 3, "or");
      vecs[8]  = mk(32'h0020F233, 0, 3'd2, 0, 32'h0,
                    5'd4, 5'd1, 5'd2, 1, 3, "and");
      vecs[9]  = mk(32'h0020A233, 0, 3'd4, 0, 32'h0,
                    5'd4, 5'd1, 5'd2, 1, 3, "slt");
      vecs[10] = mk(32'h00209463, 0, 3'd1, 0, 32'h8,
                    5'd8, 5'd1, 5'd2, 2, 3, "bne_t");
      vecs[11] = mk(32'h202081B3, 0, 3'd0, 0, 32'h0,
                    5'd3, 5'd1, 5'd2, 3, 1, "badf7");
      vecs[12] = mk(32'h8000A313, 0, 3'd4, 1, 32'hFFFFF800,
                    5'd6, 5'd1, 5'd0, 1, 3, "slti");
      vecs[13] = mk(32'hFE000EE3, 1, 3'd1, 0, 32'hFFFFFFFC,
                    5'd29, 5'd0, 5'd0, 2, 3, "beq_neg");

      rst_n       = 1'b0;
      instr_valid = 1'b0;
      instr       = '0;
      alu_eq      = 1'b0;
      repeat (3) @(negedge clk);
      chk("reset_outs", all_outs(), 0);
      rst_n = 1'b1;
      #1;
      chk("ready_pre_edge", 32'(instr_ready), 0);
      @(negedge clk);
      chk("ready_post_edge", 32'(instr_ready), 1);

      for (int i = 0; i < 14; i++)
         issue(vecs[i], 1'b0);

      // reset during EXEC of an add: no strobe may follow
      wait_ready();
      instr       = 32'h002081B3;
      alu_eq      = 1'b0;
      instr_valid = 1'b1;
      @(negedge clk);
      instr_valid = 1'b0;
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("midrst_outs", all_outs(), 0);
      @(negedge clk);
      chk("midrst_hold", all_outs(), 0);
      rst_n = 1'b1;
      #1;
      chk("midrst_ready_lo", 32'(instr_ready), 0);
      @(negedge clk);
      chk("midrst_ready_hi", 32'(instr_ready), 1);
      issue(vecs[0], 1'b0);

      // valid held high while busy: one accept, one strobe
      issue(vecs[7], 1'b1);

      repeat (6) @(negedge clk);
      chk("sb_empty", 32'(sbq.size()), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
